// File: rtl/seven_seg_scroll_buffer_pkg.sv
// Shared definitions for the seven-segment scroll buffer: digit geometry,
// FSM state encodings and the display shift helper.
package seven_seg_scroll_buffer_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DISP_W     = DIGIT_W * NUM_DIGITS;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_SCROLL = 2'd1;
    localparam state_t S_HOLD   = 2'd2;

    // New digit enters on the right; the leftmost digit falls off.
    function automatic logic [DISP_W-1:0] shift_in_digit(input logic [DISP_W-1:0]  cur,
                                                         input logic [DIGIT_W-1:0] dig);
        return {cur[DISP_W-DIGIT_W-1:0], dig};
    endfunction

endpackage

// File: rtl/seven_seg_scroll_buffer_fifo.sv
// Small first-word-fall-through FIFO holding the nibbles waiting to scroll in.
// Callers must not push when full or pop when empty.
module seven_seg_scroll_buffer_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

    // Storage array; contents are only meaningful below level, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scroll_buffer.sv
// Feeds the 4-digit seven-segment driver: buffers hex nibbles and scrolls them
// right-to-left, one digit per scroll tick, then holds the final digits.
// Optional build macro: SEVEN_SEG_SCROLL_FADE_EN (brightness ramps per tick).
module seven_seg_scroll_buffer
    import seven_seg_scroll_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned CNTR_STEP  = 1,
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [DIGIT_W-1:0]       wr_data,
    output logic                     wr_ready,
    input  logic [3:0]               lum_in,
    output logic [DISP_W-1:0]        disp_buf,
    output logic [2:0]               dp,
    output logic [3:0]               lum,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    logic [31:0]        cnt_q;
    logic [31:0]        cnt_sum;
    logic               tick;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [DIGIT_W-1:0] head;

    state_t             state_q;
    state_t             state_d;
    logic [31:0]        hold_cnt_q;
    logic [31:0]        hold_cnt_d;
    logic [DISP_W-1:0]  disp_q;
    logic [3:0]         lum_q;
    logic [3:0]         lum_d;

    assign cnt_sum = cnt_q + CNTR_STEP;
    assign tick    = (cnt_sum >= TICK_DIV);

    // Free-running scroll tick counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= tick ? '0 : cnt_sum;
        end
    end

    assign wr_ready = ~full;
    assign push     = wr_valid & ~full;
    // Every state pops on a tick when data is waiting; level is registered,
    // so a nibble pushed this cycle is never bypassed.
    assign pop      = tick & ~empty;

    seven_seg_scroll_buffer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DIGIT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // Scroll FSM next state; only advances on a tick.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        state_d = S_SCROLL;
                    end
                end
                S_SCROLL: begin
                    if (empty) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
                S_HOLD: begin
                    if (!empty) begin
                        state_d = S_SCROLL;
                    end else if (hold_cnt_q == HOLD_TICKS - 1) begin
                        state_d = S_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 32'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Display shift register; keeps its contents until the next pop or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else if (pop) begin
            disp_q <= shift_in_digit(disp_q, head);
        end
    end

`ifdef SEVEN_SEG_SCROLL_FADE_EN
    // Brightness ramps one step per tick; a lower request clamps at once.
    always_comb begin
        lum_d = lum_q;
        if (lum_in < lum_q) begin
            lum_d = lum_in;
        end else if (tick) begin
            if (state_q == S_IDLE) begin
                if (lum_q != 4'd0) begin
                    lum_d = lum_q - 4'd1;
                end
            end else if (lum_q < lum_in) begin
                lum_d = lum_q + 4'd1;
            end
        end
    end
`else
    // Brightness follows the request with one cycle of latency.
    always_comb begin
        lum_d = lum_in;
    end
`endif

    // Brightness register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lum_q <= '0;
        end else begin
            lum_q <= lum_d;
        end
    end

    assign disp_buf = disp_q;
    assign lum      = lum_q;
    assign busy     = (state_q != S_IDLE);
    // Decimal point marks the newest digit only while scrolling.
    assign dp       = (state_q == S_SCROLL) ? 3'd1 : 3'd0;

endmodule
